ifu_fetch: RTL
==============

# ifu_fetch

Multi-cycle instruction fetch unit sitting upstream of the decoder. Owns the architectural PC and issues one 32-bit fetch at a time to an instruction memory over a valid/ready request and valid response interface. Presents each fetched instruction with its PC to the decoder over a valid/ready handshake. Accepts PC redirects from execute (jal/branch), discards stale in-flight responses, and reports misaligned-PC and memory-error faults.

## Interface
- `PC_RST`, `64'h8000_0000`: PC loaded on reset.
- `ADDR_W`, 64: PC/address width.
- `INST_W`, 32: instruction width.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  ADDR_W  fetch address, equal to current PC.
- `imem_resp_valid`  in  1  response valid; one response per accepted request, ≥1 cycle after acceptance.
- `imem_resp_data`  in  INST_W  fetched instruction.
- `imem_resp_err`  in  1  access fault for this response.
- `inst_valid`  out  1  instruction available to decoder.
- `inst_ready`  in  1  decoder consumes instruction.
- `inst`  out  INST_W  instruction; 0 when `inst_fault`.
- `inst_pc`  out  ADDR_W  PC of `inst`.
- `inst_fault`  out  1  fetch fault (misaligned or memory error) for this slot.
- `redirect_valid`  in  1  redirect PC this cycle.
- `redirect_pc`  in  ADDR_W  redirect target.

## Operation
- States: IDLE, REQ, WAIT, DRAIN, HOLD, FAULT.
- IDLE: entered on reset; next cycle → REQ.
- REQ: `imem_req_valid`=1, addr=pc. If pc[1:0]≠0 → no request, HOLD with fault. On `imem_req_ready` → WAIT.
- WAIT: on `imem_resp_valid` latch data/err into output buffer → HOLD.
- HOLD: `inst_valid`=1, buffer stable until fire. On fire (`inst_valid & inst_ready`): no fault → pc+4, REQ; fault → FAULT.
- FAULT: no requests, `inst_valid`=0; stays until redirect.
- Redirect (priority over all other transitions; pc ← `redirect_pc`):
  - IDLE/REQ/HOLD/FAULT → REQ. HOLD buffer dropped; if fired same cycle the transfer counts as delivered.
  - REQ with request accepted same cycle → DRAIN.
  - WAIT without response this cycle → DRAIN; with response same cycle → response discarded, REQ.
  - DRAIN: stays DRAIN, pc updated.
- DRAIN: `imem_req_valid`=0; on `imem_resp_valid` discard response → REQ.
- At most one outstanding request at any time.
- PC arithmetic modulo 2^ADDR_W; pc+4 wraps silently.

## Timing
- Reset values: pc=PC_RST, state IDLE, `imem_req_valid`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_fault`=0.
- All outputs registered or decoded from state/registers only; no input→output combinational path.
- Zero-wait memory (ready=1, resp 1 cycle later): request cycle t, response t+1, `inst_valid` t+2; steady state 3 cycles per instruction with `inst_ready`=1.
- Redirect at cycle t: request for `redirect_pc` at t+1 unless DRAIN is required.
- Misaligned pc: `inst_valid` with fault one cycle after entering REQ.
- Reset assertion mid-transaction: immediate return to IDLE; memory is reset alongside.

## Structure
- Shared package `ifu_pkg`: state enum `ifu_state_e`, `PcRst` constant, `InstW`/`AddrW` widths.
- Single module; no sub-module required. PC and output buffer are plain async-reset registers inside the block.

## Test plan
- Reset release, mem ready=1 latency 1, data 0x00000013 → first request addr 0x80000000 at cycle 1, `inst_valid` cycle 3, `inst_pc`=0x80000000, next addr 0x80000004.
- Hold `inst_ready`=0 for 5 cycles in HOLD → `inst`/`inst_pc` stable, no new request; then ready=1 → pc 0x80000004 requested next cycle.
- Redirect to 0x80000100 in WAIT, response arrives 2 cycles later with 0xDEADBEEF → response discarded, next request addr 0x80000100, 0xDEADBEEF never presented.
- Redirect to 0x80000102 → no memory request, `inst_valid`=1, `inst_fault`=1, `inst`=0, `inst_pc`=0x80000102; after fire, no requests until redirect to 0x80000200.
- `imem_resp_err`=1 on fetch at 0x80000008 → faulted slot delivered, then FAULT state.
- Deassert-then-assert `rst` while in WAIT → all outputs at reset values, restart from 0x80000000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ifu_pkg;

   localparam int AddrW = 64;
   localparam int InstW = 32;

   // Architectural PC after reset and the sequential fetch stride.
   localparam logic [AddrW-1:0] PcRst  = 64'h0000_0000_8000_0000;
   localparam logic [AddrW-1:0] PcStep = 64'd4;

   // Fetch sequencer states:
   //   IDLE  - one cycle after reset before the first fetch
   //   REQ   - request presented to instruction memory
   //   WAIT  - request accepted, response outstanding
   //   DRAIN - response outstanding but stale (redirected), to be discarded
   //   HOLD  - fetched slot presented to the decoder
   //   FAULT - faulted slot delivered, parked until a redirect
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_HOLD  = 3'd4,
      ST_FAULT = 3'd5
   } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundles the fetch unit's memory, decoder and redirect handshakes.
// Latency: n/a (wires only).
// Backpressure: imem_req_ready stalls requests, inst_ready stalls delivery.
interface ifu_fetch_if;

   // Instruction memory request/response
   logic                        imem_req_valid;
   logic                        imem_req_ready;
   logic [ifu_pkg::AddrW-1:0]   imem_req_addr;
   logic                        imem_resp_valid;
   logic [ifu_pkg::InstW-1:0]   imem_resp_data;
   logic                        imem_resp_err;

   // Decoder handshake
   logic                        inst_valid;
   logic                        inst_ready;
   logic [ifu_pkg::InstW-1:0]   inst;
   logic [ifu_pkg::AddrW-1:0]   inst_pc;
   logic                        inst_fault;

   // Redirect from execute
   logic                        redirect_valid;
   logic [ifu_pkg::AddrW-1:0]   redirect_pc;

   // Fetch unit side
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_data, imem_resp_err,
      output inst_valid, inst, inst_pc, inst_fault,
      input  inst_ready,
      input  redirect_valid, redirect_pc
   );

   // Environment side: memory, decoder and execute
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_data, imem_resp_err,
      input  inst_valid, inst, inst_pc, inst_fault,
      output inst_ready,
      output redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one fetch at a time, hands slots to decode.
// Latency: request cycle t, response t+1, slot valid t+2 (3 cycles/instr at zero wait).
// Backpressure: slot held stable while inst_ready=0; no new request until it fires.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [AddrW-1:0] PC_RST = PcRst
) (
   input  logic         clk,
   input  logic         rst,
   ifu_fetch_if.master  bus
);

   ifu_state_e         state_q, state_d;
   logic [AddrW-1:0]   pc_q, pc_d;
   logic [InstW-1:0]   inst_q, inst_d;
   logic [AddrW-1:0]   inst_pc_q, inst_pc_d;
   logic               fault_q, fault_d;

   logic               pc_aligned;
   logic               req_fire;

   assign pc_aligned = (pc_q[1:0] == 2'b00);
   // A misaligned PC never reaches memory, so a request only fires when aligned.
   assign req_fire   = (state_q == ST_REQ) && pc_aligned && bus.imem_req_ready;

   // All outputs come from registers so no input reaches an output combinationally.
   assign bus.imem_req_valid = (state_q == ST_REQ) && pc_aligned;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = (state_q == ST_HOLD);
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.inst_fault     = fault_q;

   // Next state, next PC and output-buffer capture; redirect overrides everything.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      fault_d   = fault_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (!pc_aligned) begin
               // Fault the slot locally instead of issuing an illegal fetch.
               state_d   = ST_HOLD;
               inst_d    = '0;
               inst_pc_d = pc_q;
               fault_d   = 1'b1;
            end else if (bus.imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.imem_resp_valid) begin
               state_d   = ST_HOLD;
               inst_d    = bus.imem_resp_err ? '0 : bus.imem_resp_data;
               inst_pc_d = pc_q;
               fault_d   = bus.imem_resp_err;
            end
         end
         ST_DRAIN: begin
            if (bus.imem_resp_valid) begin
               state_d = ST_REQ;
            end
         end
         ST_HOLD: begin
            if (bus.inst_ready) begin
               if (fault_q) begin
                  state_d = ST_FAULT;
               end else begin
                  pc_d    = pc_q + PcStep;
                  state_d = ST_REQ;
               end
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc;
         // The buffer never captures a response that races a redirect; a HOLD
         // slot that fires this cycle has already been delivered to the decoder.
         inst_d    = inst_q;
         inst_pc_d = inst_pc_q;
         fault_d   = fault_q;
         case (state_q)
            // Request accepted this cycle: its response is now stale.
            ST_REQ:   state_d = req_fire ? ST_DRAIN : ST_REQ;
            // Response arriving this cycle is dropped; otherwise wait it out.
            ST_WAIT:  state_d = bus.imem_resp_valid ? ST_REQ : ST_DRAIN;
            // Only the PC moves; a response landing now still ends the drain
            // because no further response is owed.
            ST_DRAIN: state_d = bus.imem_resp_valid ? ST_REQ : ST_DRAIN;
            default:  state_d = ST_REQ;
         endcase
      end
   end

   // State, PC and output buffer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= PC_RST;
         inst_q    <= '0;
         inst_pc_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
      end
   end

endmodule
